uart_calc_ctrl: RTL and testbench

- Calculator command engine sitting directly downstream of the UART receiver and upstream of the UART transmitter.
- Consumes received ASCII bytes through the receiver's byte-valid/ACK handshake.
- Parses expressions of the form "<A><op><B><term>", computes the result, and streams the decimal ASCII answer back as TX_START/TX_DATA byte requests.
- The UART transmitter has no busy flag, so this block paces its own byte requests.

---
 rtl/uart_calc_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_calc_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_calc_ctrl.sv
// Calculator command engine between a UART receiver and transmitter.
// Parses "<A><op><B><term>", computes the result and paces the decimal answer out byte by byte.
module uart_calc_ctrl #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int TX_GAP   = (CLK_FREQ / BAUD) * 11
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic       ACK,
  output logic       TX_START,
  output logic [7:0] TX_DATA,
  output logic       BUSY
);

  localparam int GAP_W = $clog2(TX_GAP + 1);

  typedef enum logic [2:0] {
    S_A, S_B, S_FLUSH, S_CALC, S_CONV, S_SEND, S_WAIT
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

  state_t state, next_state;
  op_t    op;

  logic             rx_prev;
  logic             rx_edge, accept;
  logic             is_digit, is_op, is_term, is_space, is_lf;
  logic [15:0]      a_val, b_val, acc_in;
  logic [2:0]       a_cnt, b_cnt, cnt_in;
  logic [16:0]      acc_next;
  logic             digit_ok;
  logic [31:0]      rem, pow;
  logic [3:0]       pow_idx, dcount, wptr;
  logic             started, neg;
  logic             conv_done;
  logic [7:0]       resp [0:12];
  logic [3:0]       resp_len, tx_idx;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_done, last_byte;

  assign rx_edge  = RX_VALID & ~rx_prev;
  assign accept   = rx_edge && (state == S_A || state == S_B || state == S_FLUSH);
  assign is_digit = (RX_DATA >= 8'h30) && (RX_DATA <= 8'h39);
  assign is_op    = (RX_DATA == 8'h2B) || (RX_DATA == 8'h2D) || (RX_DATA == 8'h2A);
  assign is_term  = (RX_DATA == 8'h3D) || (RX_DATA == 8'h0D);
  assign is_space = (RX_DATA == 8'h20);
  assign is_lf    = (RX_DATA == 8'h0A);

  // With at most four digits already held, acc*10+digit stays below 2^17,
  // so bit 16 alone flags an operand above 65535.
  assign acc_in   = (state == S_A) ? a_val : b_val;
  assign cnt_in   = (state == S_A) ? a_cnt : b_cnt;
  assign acc_next = {1'b0, acc_in} * 17'd10 + {13'd0, RX_DATA[3:0]};
  assign digit_ok = (cnt_in < 3'd5) && !acc_next[16];

  always_comb begin
    pow = 32'd1;
    case (pow_idx)
      4'd0: pow = 32'd1000000000;
      4'd1: pow = 32'd100000000;
      4'd2: pow = 32'd10000000;
      4'd3: pow = 32'd1000000;
      4'd4: pow = 32'd100000;
      4'd5: pow = 32'd10000;
      4'd6: pow = 32'd1000;
      4'd7: pow = 32'd100;
      4'd8: pow = 32'd10;
      default: pow = 32'd1;
    endcase
  end

  assign conv_done = (pow_idx == 4'd9) && (rem < pow);
  assign gap_done  = (gap_cnt == GAP_W'(TX_GAP - 2));
  assign last_byte = (tx_idx == resp_len - 4'd1);
  assign BUSY      = (state == S_CALC) || (state == S_CONV) ||
                     (state == S_SEND) || (state == S_WAIT);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_A;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_A: begin
        if (accept && !is_lf && !is_space) begin
          if (is_digit) begin
            if (!digit_ok) next_state = S_FLUSH;
          end else if (is_op && a_cnt != 3'd0) begin
            next_state = S_B;
          end else begin
            next_state = S_FLUSH;
          end
        end
      end
      S_B: begin
        if (accept && !is_lf && !is_space) begin
          if (is_digit) begin
            if (!digit_ok) next_state = S_FLUSH;
          end else if (is_term && b_cnt != 3'd0) begin
            next_state = S_CALC;
          end else begin
            next_state = S_FLUSH;
          end
        end
      end
      S_FLUSH: if (accept && is_term) next_state = S_SEND;
      S_CALC:  next_state = S_CONV;
      S_CONV:  if (conv_done) next_state = S_SEND;
      S_SEND:  next_state = S_WAIT;
      S_WAIT:  if (gap_done) next_state = last_byte ? S_A : S_SEND;
      default: next_state = S_A;
    endcase
  end

  // Datapath: operand capture, arithmetic, decimal conversion and TX pacing.
  always_ff @(posedge CLK) begin
    rx_prev <= RX_VALID;
    if (RST) begin
      ACK      <= 1'b0;
      TX_START <= 1'b0;
      TX_DATA  <= 8'h00;
      a_val    <= 16'd0;
      b_val    <= 16'd0;
      a_cnt    <= 3'd0;
      b_cnt    <= 3'd0;
      op       <= OP_ADD;
      gap_cnt  <= '0;
      tx_idx   <= 4'd0;
      resp_len <= 4'd0;
      rem      <= 32'd0;
      pow_idx  <= 4'd0;
      dcount   <= 4'd0;
      wptr     <= 4'd0;
      started  <= 1'b0;
      neg      <= 1'b0;
    end else begin
      ACK      <= accept;
      TX_START <= 1'b0;
      case (state)
        S_A: begin
          if (accept && is_digit && digit_ok) begin
            a_val <= acc_next[15:0];
            a_cnt <= a_cnt + 3'd1;
          end else if (accept && is_op && a_cnt != 3'd0) begin
            case (RX_DATA)
              8'h2B:   op <= OP_ADD;
              8'h2D:   op <= OP_SUB;
              default: op <= OP_MUL;
            endcase
          end
        end
        S_B: begin
          if (accept && is_digit && digit_ok) begin
            b_val <= acc_next[15:0];
            b_cnt <= b_cnt + 3'd1;
          end
        end
        S_FLUSH: begin
          if (accept && is_term) begin
            resp[0]  <= 8'h45;
            resp[1]  <= 8'h0D;
            resp[2]  <= 8'h0A;
            resp_len <= 4'd3;
            tx_idx   <= 4'd0;
          end
        end
        S_CALC: begin
          neg     <= 1'b0;
          wptr    <= 4'd0;
          pow_idx <= 4'd0;
          dcount  <= 4'd0;
          started <= 1'b0;
          tx_idx  <= 4'd0;
          case (op)
            OP_ADD: rem <= {16'd0, a_val} + {16'd0, b_val};
            OP_MUL: rem <= {16'd0, a_val} * {16'd0, b_val};
            default: begin
              if (a_val >= b_val) begin
                rem <= {16'd0, a_val - b_val};
              end else begin
                rem     <= {16'd0, b_val - a_val};
                neg     <= 1'b1;
                resp[0] <= 8'h2D;
                wptr    <= 4'd1;
              end
            end
          endcase
        end
        // One subtraction of the current power of ten per cycle; when the
        // remainder drops below it, the digit is emitted (unless a leading zero).
        S_CONV: begin
          if (rem >= pow) begin
            rem    <= rem - pow;
            dcount <= dcount + 4'd1;
          end else begin
            if (dcount != 4'd0 || started || pow_idx == 4'd9) begin
              resp[wptr] <= 8'h30 + {4'd0, dcount};
              wptr       <= wptr + 4'd1;
              started    <= 1'b1;
            end
            if (pow_idx == 4'd9) begin
              resp[wptr + 4'd1] <= 8'h0D;
              resp[wptr + 4'd2] <= 8'h0A;
              resp_len          <= wptr + 4'd3;
            end
            dcount  <= 4'd0;
            pow_idx <= pow_idx + 4'd1;
          end
        end
        S_SEND: begin
          TX_START <= 1'b1;
          TX_DATA  <= resp[tx_idx];
          gap_cnt  <= '0;
        end
        S_WAIT: begin
          if (gap_done) begin
            tx_idx <= tx_idx + 4'd1;
            if (last_byte) begin
              a_val <= 16'd0;
              b_val <= 16'd0;
              a_cnt <= 3'd0;
              b_cnt <= 3'd0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Directed-vector bench for uart_calc_ctrl; a short TX_GAP keeps responses quick.
module tb_uart_calc_ctrl;

  localparam int TX_GAP = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       ack, tx_start, busy;
  logic [7:0] tx_data;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int ack_count = 0;
  int last_edge_cycle = 0;
  logic [7:0] tx_bytes[$];
  int         tx_times[$];

  uart_calc_ctrl #(.CLK_FREQ(1000), .BAUD(100), .TX_GAP(TX_GAP)) dut (
    .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .ACK(ack), .TX_START(tx_start), .TX_DATA(tx_data), .BUSY(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Outputs are observed on the falling edge, away from the DUT's update edge.
  always @(negedge clk) begin
    if (ack) ack_count++;
    if (tx_start) begin
      tx_bytes.push_back(tx_data);
      tx_times.push_back(cycle);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    last_edge_cycle = cycle;
    tick(1);
    rx_valid = 1'b0;
    tick(5);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    int k = 0;
    while (tx_bytes.size() < n && k < 1500) begin
      tick(1);
      k++;
    end
    ok = (tx_bytes.size() >= n);
    tick(TX_GAP + 4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0", ack); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_start: got %b expected 0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick(2);
  endtask

  // Sends a full command and checks the whole response, its pacing and the idle state afterwards.
  task automatic test_expr(input string name, input string cmd, input string resp);
    bit ok;
    tx_bytes.delete();
    tx_times.delete();
    send_str(cmd);
    wait_bytes(resp.len(), ok);
    vectors++;
    if (!ok || tx_bytes.size() != resp.len()) begin
      miscompares++;
      $display("[TB] FAIL %s_count: got %0d bytes expected %0d", name, tx_bytes.size(), resp.len());
    end
    for (int i = 0; i < resp.len() && i < tx_bytes.size(); i++) begin
      vectors++;
      if (tx_bytes[i] !== resp[i]) begin
        miscompares++;
        $display("[TB] FAIL %s_byte%0d: got %h expected %h", name, i, tx_bytes[i], resp[i]);
      end
    end
    for (int i = 1; i < tx_times.size(); i++) begin
      vectors++;
      if (tx_times[i] - tx_times[i-1] != TX_GAP) begin
        miscompares++;
        $display("[TB] FAIL %s_gap%0d: got %0d expected %0d", name, i, tx_times[i] - tx_times[i-1], TX_GAP);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_idle_busy: got %b expected 0", name, busy); end
  endtask

  task automatic test_add();
    int a0 = ack_count;
    test_expr("add", "12+34=", "46\r\n");
    vectors++;
    if (ack_count - a0 != 6) begin miscompares++; $display("[TB] FAIL add_acks: got %0d expected 6", ack_count - a0); end
    vectors++;
    if (tx_times.size() == 0 || tx_times[0] - last_edge_cycle > 110) begin
      miscompares++;
      $display("[TB] FAIL add_latency: got %0d expected <=110", tx_times.size() == 0 ? -1 : tx_times[0] - last_edge_cycle);
    end
  endtask

  task automatic test_sub();
    int a0 = ack_count;
    test_expr("sub", "5 - 9\r", "-4\r\n");
    vectors++;
    if (ack_count - a0 != 6) begin miscompares++; $display("[TB] FAIL sub_acks: got %0d expected 6", ack_count - a0); end
  endtask

  task automatic test_mul();
    test_expr("mul_max", "65535*65535=", "4294836225\r\n");
    test_expr("mul_zero", "0*7=", "0\r\n");
  endtask

  task automatic test_errors();
    test_expr("err_badop", "7/2=", "E\r\n");
    test_expr("err_6digit", "123456+1=", "E\r\n");
    test_expr("err_noA", "+3=", "E\r\n");
    test_expr("after_err", "0+0=", "0\r\n");
  endtask

  task automatic test_busy();
    bit ok;
    tx_bytes.delete();
    tx_times.delete();
    send_str("1+1");
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_in_b: got %b expected 0", busy); end
    rx_data = 8'h3D;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_after_term: got %b expected 1", busy); end
    vectors++;
    if (ack !== 1'b1) begin miscompares++; $display("[TB] FAIL ack_after_term: got %b expected 1", ack); end
    tick(1);
    vectors++;
    if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL ack_one_cycle: got %b expected 0", ack); end
    wait_bytes(3, ok);
    vectors++;
    if (!ok || tx_bytes[0] !== 8'h32) begin miscompares++; $display("[TB] FAIL busy_result: got %0d bytes expected 3", tx_bytes.size()); end
  endtask

  task automatic test_hold_and_drop();
    int a0 = ack_count;
    bit ok;
    int k = 0;
    rx_data = 8'h38;
    rx_valid = 1'b1;
    tick(4);
    rx_valid = 1'b0;
    tick(3);
    vectors++;
    if (ack_count - a0 != 1) begin miscompares++; $display("[TB] FAIL hold_acks: got %0d expected 1", ack_count - a0); end
    test_expr("hold", "+1=", "9\r\n");
    tx_bytes.delete();
    tx_times.delete();
    send_str("3*3=");
    while (tx_bytes.size() < 1 && k < 500) begin tick(1); k++; end
    a0 = ack_count;
    send_byte(8'h35);
    vectors++;
    if (ack_count - a0 != 0) begin miscompares++; $display("[TB] FAIL drop_acks: got %0d expected 0", ack_count - a0); end
    wait_bytes(3, ok);
    vectors++;
    if (!ok || tx_bytes.size() != 3) begin miscompares++; $display("[TB] FAIL drop_count: got %0d expected 3", tx_bytes.size()); end
    for (int i = 0; i < 3 && i < tx_bytes.size(); i++) begin
      vectors++;
      if (tx_bytes[i] !== (i == 0 ? 8'h39 : (i == 1 ? 8'h0D : 8'h0A))) begin
        miscompares++;
        $display("[TB] FAIL drop_byte%0d: got %h", i, tx_bytes[i]);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    int k = 0;
    int n;
    tx_bytes.delete();
    tx_times.delete();
    send_str("99+1=");
    while (tx_bytes.size() < 2 && k < 1500) begin tick(1); k++; end
    vectors++;
    if (tx_bytes.size() != 2 || tx_bytes[0] !== 8'h31 || tx_bytes[1] !== 8'h30) begin
      miscompares++;
      $display("[TB] FAIL midrst_prefix: got %0d bytes expected 2 (1,0)", tx_bytes.size());
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_tx_start: got %b expected 0", tx_start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL midrst_tx_data: got %h expected 00", tx_data); end
    n = tx_bytes.size();
    tick(3 * TX_GAP);
    vectors++;
    if (tx_bytes.size() != n) begin miscompares++; $display("[TB] FAIL midrst_extra: got %0d bytes expected %0d", tx_bytes.size(), n); end
    test_expr("after_midrst", "2*3=", "6\r\n");
  endtask

  task automatic test_reset_vs_edge();
    int a0 = ack_count;
    rst = 1'b1;
    rx_data = 8'h37;
    rx_valid = 1'b1;
    tick(1);
    rst = 1'b0;
    vectors++;
    if (ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rstedge_ack: got %b expected 0", ack); end
    tick(2);
    rx_valid = 1'b0;
    tick(2);
    vectors++;
    if (ack_count - a0 != 0) begin miscompares++; $display("[TB] FAIL rstedge_acks: got %0d expected 0", ack_count - a0); end
    test_expr("after_rstedge", "1+2=", "3\r\n");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_errors();
    test_busy();
    test_hold_and_drop();
    test_reset_mid_send();
    test_reset_vs_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
